// File: rtl/iter_alu_if.sv
// Request/result handshake bundle between a requester (master) and iter_alu (slave).
interface iter_alu_if #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [IMM_WIDTH-1:0] imm;
    logic [1:0]           alu_src;
    logic [3:0]           func;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out;
    logic                 c_out;
    logic                 branch_taken;
    logic                 busy;

    modport master (
        output in_valid, A, B, imm, alu_src, func, out_ready,
        input  in_ready, out_valid, out, c_out, branch_taken, busy
    );

    modport slave (
        input  in_valid, A, B, imm, alu_src, func, out_ready,
        output in_ready, out_valid, out, c_out, branch_taken, busy
    );
endinterface

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle arithmetic/logic, bit-serial shifts and optional shift-add MUL.
// Define ITER_ALU_MUL_EN to build the iterative multiplier; otherwise func 1111 returns 0.
module iter_alu #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16
) (
    input logic        clk,
    input logic        rst,
    iter_alu_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
    typedef enum logic [3:0] {
        OP_ADD, OP_ADDI, OP_LOAD, OP_STORE, OP_LUI, OP_JUMP, OP_OR, OP_AND,
        OP_BRANCH, OP_SUB, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_MUL
    } op_e;

    state_e           state_q;
    logic [3:0]       func_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q;
    logic             c_out_q, branch_q, out_valid_q;

    logic [WIDTH-1:0] sel_b, res_d;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic             carry_d, br_d, is_shift, is_mul;

`ifdef ITER_ALU_MUL_EN
    localparam logic [CW-1:0] MUL_CNT = CW'(WIDTH);
    logic [WIDTH-1:0] mcand_q, mplier_q;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        case (bus.alu_src)
            2'b01:   sel_b = {{(WIDTH-IMM_WIDTH){1'b0}}, bus.imm};
            2'b10:   sel_b = {{(WIDTH-IMM_WIDTH){bus.imm[IMM_WIDTH-1]}}, bus.imm};
            default: sel_b = bus.B;
        endcase
        shamt    = sel_b[SHW-1:0];
        sum      = {1'b0, bus.A} + {1'b0, sel_b};
        res_d    = '0;
        carry_d  = 1'b0;
        br_d     = 1'b0;
        is_shift = 1'b0;
        case (bus.func)
            OP_ADD, OP_ADDI, OP_LOAD, OP_STORE: begin
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            OP_LUI:  res_d = sel_b << IMM_WIDTH;
            OP_JUMP: begin
                res_d = sel_b;
                br_d  = 1'b1;
            end
            OP_OR:   res_d = bus.A | sel_b;
            OP_AND:  res_d = bus.A & sel_b;
            OP_BRANCH, OP_SUB: begin
                res_d   = bus.A - sel_b;
                carry_d = (bus.A >= sel_b);
                br_d    = (bus.func == OP_BRANCH) && (bus.A == sel_b);
            end
            OP_XOR:  res_d = bus.A ^ sel_b;
            OP_SLL, OP_SRL, OP_SRA: begin
                // A zero shift amount completes immediately with A unchanged.
                res_d    = bus.A;
                is_shift = (shamt != '0);
            end
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(sel_b))};
            default: res_d = '0;
        endcase
`ifdef ITER_ALU_MUL_EN
        is_mul = (bus.func == OP_MUL);
`else
        is_mul = 1'b0;
`endif
    end

    always_comb begin
        acc_d = acc_q;
        case (func_q)
            OP_SLL:  acc_d = acc_q << 1;
            OP_SRL:  acc_d = acc_q >> 1;
            OP_SRA:  acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
`ifdef ITER_ALU_MUL_EN
            OP_MUL:  acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
`endif
            default: acc_d = acc_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            func_q      <= OP_ADD;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            c_out_q     <= 1'b0;
            branch_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ITER_ALU_MUL_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    func_q <= bus.func;
`ifdef ITER_ALU_MUL_EN
                    mcand_q  <= bus.A;
                    mplier_q <= sel_b;
`endif
                    if (is_shift || is_mul) begin
                        state_q <= EXEC;
                        acc_q   <= is_mul ? '0 : bus.A;
`ifdef ITER_ALU_MUL_EN
                        cnt_q   <= is_mul ? MUL_CNT : {1'b0, shamt};
`else
                        cnt_q   <= {1'b0, shamt};
`endif
                    end else begin
                        state_q     <= DONE;
                        out_q       <= res_d;
                        c_out_q     <= carry_d;
                        branch_q    <= br_d;
                        out_valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
`ifdef ITER_ALU_MUL_EN
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
`endif
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_q       <= acc_d;
                        c_out_q     <= 1'b0;
                        branch_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == IDLE) && !rst;
    assign bus.busy         = (state_q != IDLE);
    assign bus.out_valid    = out_valid_q;
    assign bus.out          = out_q;
    assign bus.c_out        = c_out_q;
    assign bus.branch_taken = branch_q;
endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu (WIDTH 32, IMM_WIDTH 16); honours ITER_ALU_MUL_EN.
module tb_iter_alu;
    localparam logic [3:0] ADD = 4'h0, ADDI = 4'h1, LUI = 4'h4, JUMP = 4'h5, OR_ = 4'h6,
                           AND_ = 4'h7, BRANCH = 4'h8, SUB = 4'h9, XOR_ = 4'hA, SLL = 4'hB,
                           SRL = 4'hC, SRA = 4'hD, SLT = 4'hE, MUL = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    iter_alu_if #(.WIDTH(32), .IMM_WIDTH(16)) bus_if ();

    iter_alu #(.WIDTH(32), .IMM_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] im, input logic [1:0] src);
        bus_if.func    = f;
        bus_if.A       = a;
        bus_if.B       = b;
        bus_if.imm     = im;
        bus_if.alu_src = src;
        bus_if.in_valid = 1'b1;
        check({tag, " in_ready"}, bus_if.in_ready, 1);
        tick();
        bus_if.in_valid = 1'b0;
    endtask

    // Counts cycles from acceptance until out_valid, watching in_ready stays low meanwhile.
    task automatic wait_valid(input string tag, input int exp_lat);
        int   lat = 1;
        logic ready_seen = 1'b0;
        while (!bus_if.out_valid && lat < exp_lat + 5) begin
            if (bus_if.in_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " in_ready low"}, ready_seen, 0);
    endtask

    task automatic consume(input string tag);
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check({tag, " idle"}, {bus_if.in_ready, bus_if.busy, bus_if.out_valid}, 3'b100);
    endtask

    task automatic op1(input string tag, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] im, input logic [1:0] src,
                       input int lat, input logic [31:0] exp_out, input logic exp_c,
                       input logic exp_br);
        issue(tag, f, a, b, im, src);
        wait_valid(tag, lat);
        check({tag, " out"}, bus_if.out, exp_out);
        check({tag, " c_out"}, bus_if.c_out, exp_c);
        check({tag, " branch"}, bus_if.branch_taken, exp_br);
        consume(tag);
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.A = '0; bus_if.B = '0; bus_if.imm = '0; bus_if.alu_src = '0; bus_if.func = '0;

        tick();
        tick();
        check("reset in_ready", bus_if.in_ready, 0);
        check("reset outputs", {bus_if.out_valid, bus_if.c_out, bus_if.branch_taken, bus_if.busy}, 4'b0000);
        check("reset out", bus_if.out, 0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", bus_if.in_ready, 1);

        op1("add_wrap", ADD,    32'hFFFF_FFFF, 32'h1,  16'h0,    2'b00, 1, 32'h0,          1, 0);
        op1("br_eq",    BRANCH, 32'h10,        32'h0,  16'h0010, 2'b01, 1, 32'h0,          1, 1);
        op1("br_ne",    BRANCH, 32'h10,        32'h0,  16'h0011, 2'b01, 1, 32'hFFFF_FFFF, 0, 0);
        op1("sra4",     SRA,    32'h8000_0000, 32'h4,  16'h0,    2'b00, 5, 32'hF800_0000,  0, 0);
        op1("sra0",     SRA,    32'h8000_0000, 32'h0,  16'h0,    2'b00, 1, 32'h8000_0000,  0, 0);
        op1("sll31",    SLL,    32'h1,         32'h0,  16'h001F, 2'b01, 32, 32'h8000_0000, 0, 0);
        op1("srl1",     SRL,    32'h8000_0000, 32'h21, 16'h0,    2'b11, 2, 32'h4000_0000,  0, 0);
        op1("sub_neg",  SUB,    32'h5,         32'h7,  16'h0,    2'b00, 1, 32'hFFFF_FFFE,  0, 0);
        op1("sub_pos",  SUB,    32'h7,         32'h5,  16'h0,    2'b00, 1, 32'h2,          1, 0);
        op1("lui",      LUI,    32'h0,         32'h0,  16'h1234, 2'b01, 1, 32'h1234_0000,  0, 0);
        op1("jump",     JUMP,   32'h0,         32'h0,  16'h8000, 2'b10, 1, 32'hFFFF_8000,  0, 1);
        op1("slt_t",    SLT,    32'hFFFF_FFFF, 32'h1,  16'h0,    2'b00, 1, 32'h1,          0, 0);
        op1("slt_f",    SLT,    32'h1,         32'hFFFF_FFFF, 16'h0, 2'b00, 1, 32'h0,      0, 0);
        op1("or",       OR_,    32'hF0F0,      32'h0FF0, 16'h0,  2'b00, 1, 32'hFFF0,       0, 0);
        op1("and",      AND_,   32'hF0F0,      32'h0FF0, 16'h0,  2'b00, 1, 32'h00F0,       0, 0);
        op1("xor",      XOR_,   32'hF0F0,      32'h0FF0, 16'h0,  2'b00, 1, 32'hFF00,       0, 0);
        op1("addi_sx",  ADDI,   32'h10,        32'h0,  16'hFFFF, 2'b10, 1, 32'hF,          1, 0);

        // Back-pressure: result must stay put and new requests must be ignored.
        issue("bp", ADD, 32'h3, 32'h4, 16'h0, 2'b00);
        bus_if.func = SUB; bus_if.A = 32'h100; bus_if.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp hold", {bus_if.out_valid, bus_if.in_ready, bus_if.out}, {2'b10, 32'h7});
            tick();
        end
        bus_if.in_valid = 1'b0;
        check("bp final out", bus_if.out, 32'h7);
        consume("bp");

`ifdef ITER_ALU_MUL_EN
        op1("mul", MUL, 32'h0001_0000, 32'h0, 16'hFFFF, 2'b10, 33, 32'hFFFF_0000, 0, 0);
        issue("rst_mid", MUL, 32'h1234, 32'h0, 16'h7, 2'b01);
`else
        op1("mul_off", MUL, 32'h0001_0000, 32'h0, 16'hFFFF, 2'b10, 1, 32'h0, 0, 0);
        issue("rst_mid", SLL, 32'h1234, 32'h0, 16'h1F, 2'b01);
`endif
        for (int i = 1; i < 10; i++) tick();
        check("rst_mid busy", bus_if.busy, 1);
        rst = 1'b1;
        bus_if.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.out_ready = 1'b0;
        #1;
        check("rst_mid after", {bus_if.busy, bus_if.out_valid, bus_if.in_ready}, 3'b001);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (bus_if.out_valid) seen = 1'b1;
                tick();
            end
            check("rst_mid no result", seen, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, SHALL be a power of two, at least 8.
REQ-002 Parameter IMM_WIDTH, default 16: immediate field width, SHALL be less than WIDTH.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand.
REQ-009 imm  input  IMM_WIDTH  immediate.
REQ-010 alu_src  input  2  B select: 00 B, 01 zero-extended imm, 10 sign-extended imm, 11 B.
REQ-011 func  input  4  operation code.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out  output  WIDTH  result.
REQ-015 c_out  output  1  carry out.
REQ-016 branch_taken  output  1  branch/jump decision.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 Operand B selection (selB) SHALL be computed from B/imm/alu_src at acceptance and latched with A and func.
REQ-019 Opcodes SHALL be: 0000 ADD, 0001 ADDI, 0010 LOAD, 0011 STORE (all A+selB), 0100 LUI (selB shifted left by IMM_WIDTH, zero-filled), 0101 JUMP (selB), 0110 OR, 0111 AND, 1000 BRANCH (A-selB), 1001 SUB, 1010 XOR, 1011 SLL, 1100 SRL, 1101 SRA, 1110 SLT (signed, result 1 or 0), 1111 MUL (low WIDTH bits of A*selB).
REQ-020 FSM states IDLE, EXEC, DONE; in_ready SHALL equal (state==IDLE && !rst).
REQ-021 Acceptance SHALL occur on a cycle with in_valid && in_ready; requests while not IDLE are ignored.
REQ-022 Single-cycle ops (all except shifts and MUL) SHALL go IDLE->DONE; out_valid high the cycle after acceptance.
REQ-023 Shifts SHALL use shamt = selB[log2(WIDTH)-1:0], shift one bit per EXEC cycle, out_valid asserted shamt+1 cycles after acceptance; shamt 0 SHALL go IDLE->DONE directly with out = A.
REQ-024 SRA SHALL replicate A's MSB; SLL/SRL SHALL fill zeros.
REQ-025 MUL SHALL be iterative shift-add, exactly WIDTH EXEC cycles, out_valid WIDTH+1 cycles after acceptance; overflow bits discarded.
REQ-026 DONE SHALL hold out, c_out, branch_taken stable until out_valid && out_ready, then go IDLE; next request acceptable the following cycle.
REQ-027 c_out SHALL be bit WIDTH of the (WIDTH+1)-bit sum for ADD/ADDI/LOAD/STORE, inverted borrow (A>=selB unsigned) for SUB/BRANCH, 0 otherwise.
REQ-028 branch_taken SHALL be 1 for JUMP, 1 for BRANCH when A==selB, 0 otherwise.
REQ-029 Undefined behaviour SHALL not exist: all 16 codes defined.

Reset
REQ-030 On rst: state IDLE, out_valid 0, out 0, c_out 0, branch_taken 0, busy 0, iteration counter 0.
REQ-031 rst asserted during EXEC or DONE SHALL abort the operation; no result is delivered.
REQ-032 rst SHALL take precedence over a simultaneous in_valid or out_ready.

Configuration
REQ-033 Macro ITER_ALU_MUL_EN: when defined, MUL per REQ-025.
REQ-034 Without ITER_ALU_MUL_EN: no multiplier datapath is built; func 1111 SHALL complete as single-cycle op with out 0, c_out 0, branch_taken 0.

Verification
REQ-035 ADD A=0xFFFFFFFF, B=0x00000001, alu_src 00 -> next cycle out_valid=1, out=0x00000000, c_out=1.
REQ-036 BRANCH A=0x10, imm=0x0010, alu_src 01 -> out=0, branch_taken=1; with imm=0x0011 -> branch_taken=0, out=0xFFFFFFFF.
REQ-037 SRA A=0x80000000, B=4 -> out_valid 5 cycles after acceptance, out=0xF8000000; B=0 -> 1 cycle, out=0x80000000.
REQ-038 MUL (macro defined) A=0x00010000, imm=0xFFFF, alu_src 10 -> out_valid 33 cycles after acceptance, out=0xFFFF0000; in_ready low throughout.
REQ-039 Result back-pressure: out_ready low 10 cycles after ADD 3+4 -> out=7 held stable, in_ready low; release -> IDLE next cycle.
REQ-040 rst asserted mid-MUL cycle 10 -> following cycle busy=0, out_valid=0, in_ready=1; no result later emerges.
